// File: rtl/sap2_tstate_sequencer.sv
// sap2_tstate_sequencer: SAP-2 T-state ring, opcode latch/decode, halt and single-step control.
module sap2_tstate_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iRingReset,
    input  logic        iLir,
    input  logic [7:0]  iBus,
    input  logic        iManual,
    input  logic        iStep,
    output logic [17:0] oTstate,
    output logic [7:0]  oOpcode,
    output logic [28:0] oDecode,
    output logic        oHalted,
    output logic        oIllegal,
    output logic        oOverrun
);
    localparam logic [17:0] T0 = 18'h00001;
    localparam logic [17:0] TNONE = 18'h00000;
    logic [SYNC_STAGES-1:0] stepSync;
    logic stepPrev;
    logic adv;
    logic forced;
    logic enterHalt;
    // Manual mode advances once per synchronised rising edge of iStep
    assign adv = iManual ? (stepSync[SYNC_STAGES-1] & ~stepPrev) : 1'b1;
    assign forced = oTstate[3] & oIllegal & ILLEGAL_AS_NOP;
    assign enterHalt = oTstate[3] & (oDecode[6] | (oIllegal & ~ILLEGAL_AS_NOP));
    assign oIllegal = ~|oDecode;
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            oTstate  <= T0;
            oOpcode  <= 8'h00;
            oHalted  <= 1'b0;
            oOverrun <= 1'b0;
            stepSync <= '0;
            stepPrev <= 1'b0;
        end else begin
            stepSync <= {stepSync[SYNC_STAGES-2:0], iStep};
            stepPrev <= stepSync[SYNC_STAGES-1];
            oOverrun <= 1'b0;
            if (adv && iLir) oOpcode <= iBus;
            if (adv && !oHalted) begin
                if (enterHalt) begin
                    oHalted <= 1'b1;
                    oTstate <= TNONE;
                end else if (iRingReset || forced) begin
                    oTstate <= T0;
                end else if (oTstate[17]) begin
                    oTstate  <= T0;
                    oOverrun <= 1'b1;
                end else begin
                    oTstate <= {oTstate[16:0], 1'b0};
                end
            end
        end
    end
    always_comb begin
        oDecode = '0;
        case (oOpcode)
            8'h80: oDecode[0]  = 1'b1;
            8'h81: oDecode[1]  = 1'b1;
            8'hA0: oDecode[2]  = 1'b1;
            8'hA1: oDecode[3]  = 1'b1;
            8'hCD: oDecode[4]  = 1'b1;
            8'h3D: oDecode[5]  = 1'b1;
            8'h76: oDecode[6]  = 1'b1;
            8'hDB: oDecode[7]  = 1'b1;
            8'h3C: oDecode[8]  = 1'b1;
            8'hC3: oDecode[9]  = 1'b1;
            8'hCA: oDecode[10] = 1'b1;
            8'h3A: oDecode[11] = 1'b1;
            8'h78: oDecode[12] = 1'b1;
            8'h79: oDecode[13] = 1'b1;
            8'h47: oDecode[14] = 1'b1;
            8'h4F: oDecode[15] = 1'b1;
            8'h3E: oDecode[16] = 1'b1;
            8'h00: oDecode[17] = 1'b1;
            8'hB0: oDecode[18] = 1'b1;
            8'hB1: oDecode[19] = 1'b1;
            8'hD3: oDecode[20] = 1'b1;
            8'h17: oDecode[21] = 1'b1;
            8'h1F: oDecode[22] = 1'b1;
            8'hC9: oDecode[23] = 1'b1;
            8'h32: oDecode[24] = 1'b1;
            8'h90: oDecode[25] = 1'b1;
            8'h91: oDecode[26] = 1'b1;
            8'hA8: oDecode[27] = 1'b1;
            8'hA9: oDecode[28] = 1'b1;
            default: oDecode = '0;
        endcase
    end
endmodule
